// File: rtl/i2c_slave_if.sv
// I2C slave responder: oversampled SCL/SDA, START/STOP detection, 7-bit address match,
// write bytes delivered to the user side, read bytes requested from it and shifted out open-drain.
`timescale 1ns/1ps
module i2c_slave_if #(
  parameter int I2C_ADDR_WIDTH = 7,
  parameter int I2C_DATA_WIDTH = 8,
  parameter logic [I2C_ADDR_WIDTH-1:0] I2C_DEVICE_ADDR = 7'h22
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      scl_i,
  input  logic                      sda_i,
  output logic                      scl_o,
  output logic                      sda_o,
  output logic                      start_o,
  output logic                      stop_o,
  output logic                      addr_match_o,
  output logic                      op_o,
  output logic                      wr_valid_o,
  output logic [I2C_DATA_WIDTH-1:0] wr_data_o,
  output logic                      rd_req_o,
  input  logic [I2C_DATA_WIDTH-1:0] rd_data_i,
  output logic                      busy_o
);

  localparam int CNT_W = $clog2(I2C_DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(I2C_ADDR_WIDTH);
  localparam logic [CNT_W-1:0] ADDR_FULL = CNT_W'(I2C_ADDR_WIDTH + 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(I2C_DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] DATA_FULL = CNT_W'(I2C_DATA_WIDTH);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ADDR     = 3'd1;
  localparam logic [2:0] S_ADDR_ACK = 3'd2;
  localparam logic [2:0] S_WR_BYTE  = 3'd3;
  localparam logic [2:0] S_WR_ACK   = 3'd4;
  localparam logic [2:0] S_RD_BYTE  = 3'd5;
  localparam logic [2:0] S_RD_ACK   = 3'd6;
  localparam logic [2:0] S_IGNORE   = 3'd7;

  logic scl_p0, scl_p1, scl_p2;
  logic sda_p0, sda_p1, sda_p2;
  logic scl_rise, scl_fall, start_det, stop_det;

  logic [2:0]                state;
  logic [CNT_W-1:0]          cnt;
  logic [I2C_DATA_WIDTH-1:0] shift;
  logic [I2C_DATA_WIDTH-1:0] byte_in;
  logic                      addr_hit;

  assign scl_o = 1'b1;

  // p0/p1: two-stage synchronizer, p2: previous synchronized value for edge detection
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      {scl_p0, scl_p1, scl_p2} <= 3'b111;
      {sda_p0, sda_p1, sda_p2} <= 3'b111;
    end else begin
      {scl_p0, scl_p1, scl_p2} <= {scl_i, scl_p0, scl_p1};
      {sda_p0, sda_p1, sda_p2} <= {sda_i, sda_p0, sda_p1};
    end
  end

  assign scl_rise  = scl_p1 & ~scl_p2;
  assign scl_fall  = ~scl_p1 & scl_p2;
  // SCL must be high on both samples so an SCL/SDA change in the same cycle is not a condition
  assign start_det = sda_p2 & ~sda_p1 & scl_p1 & scl_p2;
  assign stop_det  = ~sda_p2 & sda_p1 & scl_p1 & scl_p2;

  assign byte_in  = {shift[I2C_DATA_WIDTH-2:0], sda_p1};
  assign addr_hit = (shift[I2C_ADDR_WIDTH-1:0] == I2C_DEVICE_ADDR);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state        <= S_IDLE;
      cnt          <= '0;
      shift        <= '0;
      sda_o        <= 1'b1;
      start_o      <= 1'b0;
      stop_o       <= 1'b0;
      addr_match_o <= 1'b0;
      op_o         <= 1'b0;
      wr_valid_o   <= 1'b0;
      wr_data_o    <= '0;
      rd_req_o     <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      start_o    <= 1'b0;
      stop_o     <= 1'b0;
      wr_valid_o <= 1'b0;
      rd_req_o   <= 1'b0;
      if (start_det) begin
        state        <= S_ADDR;
        cnt          <= '0;
        sda_o        <= 1'b1;
        start_o      <= 1'b1;
        busy_o       <= 1'b1;
        addr_match_o <= 1'b0;
      end else if (stop_det) begin
        state        <= S_IDLE;
        sda_o        <= 1'b1;
        stop_o       <= 1'b1;
        busy_o       <= 1'b0;
        addr_match_o <= 1'b0;
      end else begin
        case (state)
          S_ADDR: begin
            if (scl_rise && cnt != ADDR_FULL) begin
              shift <= byte_in;
              cnt   <= cnt + 1'b1;
              if (cnt == ADDR_LAST) begin
                if (addr_hit) op_o  <= sda_p1;
                else          state <= S_IGNORE;
              end
            end else if (scl_fall && cnt == ADDR_FULL) begin
              sda_o        <= 1'b0;
              addr_match_o <= 1'b1;
              state        <= S_ADDR_ACK;
            end
          end
          S_ADDR_ACK: begin
            if (scl_rise) begin
              rd_req_o <= op_o;
            end else if (scl_fall) begin
              if (op_o) begin
                shift <= rd_data_i;
                sda_o <= rd_data_i[I2C_DATA_WIDTH-1];
                cnt   <= CNT_W'(1);
                state <= S_RD_BYTE;
              end else begin
                sda_o <= 1'b1;
                cnt   <= '0;
                state <= S_WR_BYTE;
              end
            end
          end
          S_WR_BYTE: begin
            if (scl_rise && cnt != DATA_FULL) begin
              shift <= byte_in;
              cnt   <= cnt + 1'b1;
              if (cnt == DATA_LAST) begin
                wr_data_o  <= byte_in;
                wr_valid_o <= 1'b1;
              end
            end else if (scl_fall && cnt == DATA_FULL) begin
              sda_o <= 1'b0;
              state <= S_WR_ACK;
            end
          end
          S_WR_ACK: begin
            if (scl_fall) begin
              sda_o <= 1'b1;
              cnt   <= '0;
              state <= S_WR_BYTE;
            end
          end
          S_RD_BYTE: begin
            if (scl_fall) begin
              if (cnt == DATA_FULL) begin
                sda_o <= 1'b1;
                state <= S_RD_ACK;
              end else begin
                sda_o <= shift[I2C_DATA_WIDTH-2];
                shift <= {shift[I2C_DATA_WIDTH-2:0], 1'b0};
                cnt   <= cnt + 1'b1;
              end
            end
          end
          S_RD_ACK: begin
            if (scl_rise) begin
              if (sda_p1) state    <= S_IGNORE;
              else        rd_req_o <= 1'b1;
            end else if (scl_fall) begin
              shift <= rd_data_i;
              sda_o <= rd_data_i[I2C_DATA_WIDTH-1];
              cnt   <= CNT_W'(1);
              state <= S_RD_BYTE;
            end
          end
          S_IGNORE: sda_o <= 1'b1;
          default:  sda_o <= 1'b1;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_if.sv
// Bench for i2c_slave_if: bit-banged I2C master on a wired-AND bus, with transaction-level
// expectations (queues of bytes, pulse counters) compared against what the bus and user side see.
`timescale 1ns/1ps
module tb_i2c_slave_if;

  localparam int Q = 4;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       scl_m, sda_m;
  logic       scl_o, sda_o, start_o, stop_o, addr_match_o, op_o;
  logic       wr_valid_o, rd_req_o, busy_o;
  logic [7:0] wr_data_o;
  logic [7:0] rd_data_i;
  wire        sda_bus = sda_m & sda_o;

  int n_tests = 0;
  int n_fail  = 0;
  int start_cnt = 0, stop_cnt = 0, rd_req_cnt = 0;
  logic [7:0] wr_got[$];
  logic [7:0] rd_src[$];

  i2c_slave_if dut (
    .clk_i(clk_i), .rst_i(rst_i), .scl_i(scl_m), .sda_i(sda_bus),
    .scl_o(scl_o), .sda_o(sda_o), .start_o(start_o), .stop_o(stop_o),
    .addr_match_o(addr_match_o), .op_o(op_o), .wr_valid_o(wr_valid_o),
    .wr_data_o(wr_data_o), .rd_req_o(rd_req_o), .rd_data_i(rd_data_i),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  // User side: counts pulses, collects write bytes, serves read bytes on request
  initial begin
    rd_data_i = 8'h00;
    forever begin
      @(negedge clk_i);
      if (start_o) start_cnt++;
      if (stop_o) stop_cnt++;
      if (wr_valid_o) wr_got.push_back(wr_data_o);
      if (rd_req_o) begin
        rd_req_cnt++;
        rd_data_i = (rd_src.size() > 0) ? rd_src.pop_front() : 8'hEE;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_q();
    repeat (Q) @(negedge clk_i);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b0;
  endtask

  task automatic bus_stop();
    wait_q(); sda_m = 1'b0;
    wait_q(); scl_m = 1'b1;
    wait_q(); sda_m = 1'b1;
    wait_q();
  endtask

  task automatic put_bit(input logic b);
    wait_q(); sda_m = b;
    wait_q(); scl_m = 1'b1;
    wait_q(); wait_q(); scl_m = 1'b0;
  endtask

  task automatic get_bit(output logic b);
    wait_q(); sda_m = 1'b1;
    wait_q(); scl_m = 1'b1;
    wait_q(); b = sda_bus;
    wait_q(); scl_m = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    get_bit(ack);
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      d[i] = b;
    end
    put_bit(nack);
  endtask

  // One transaction judged from the protocol rules: ACK only for 0x22, every write byte ACKed,
  // every read byte equals what the user side supplied, one rd_req per read byte.
  task automatic xfer(input logic [6:0] addr, input logic rd, input logic [7:0] data[$],
                      input bit do_stop, input string tag);
    logic ack;
    logic [7:0] got;
    logic [31:0] v;
    bit hit;
    int wr_base, st0, sp0, rq0;
    hit = (addr == 7'h22);
    wr_base = wr_got.size();
    st0 = start_cnt; sp0 = stop_cnt; rq0 = rd_req_cnt;
    if (hit && rd) foreach (data[i]) rd_src.push_back(data[i]);
    bus_start();
    send_byte({addr, rd}, ack);
    check({tag, " addr_ack"}, ack, hit ? 0 : 1);
    check({tag, " start_pulses"}, start_cnt - st0, 1);
    check({tag, " addr_match"}, addr_match_o, hit);
    check({tag, " busy"}, busy_o, 1);
    if (hit) check({tag, " op"}, op_o, rd);
    if (!hit) begin
      send_byte(8'hA5, ack);
      check({tag, " ignored_ack"}, ack, 1);
    end else if (!rd) begin
      foreach (data[i]) begin
        send_byte(data[i], ack);
        check({tag, " wr_ack"}, ack, 0);
      end
    end else begin
      for (int i = 0; i < data.size(); i++) begin
        recv_byte(i == data.size() - 1, got);
        check({tag, " rd_byte"}, got, data[i]);
      end
      check({tag, " sda_released"}, sda_o, 1);
    end
    check({tag, " rd_req_pulses"}, rd_req_cnt - rq0, (hit && rd) ? data.size() : 0);
    check({tag, " wr_pulses"}, wr_got.size() - wr_base, (hit && !rd) ? data.size() : 0);
    if (hit && !rd) begin
      foreach (data[i]) begin
        v = 'x;
        if (wr_base + i < wr_got.size()) v = 32'(wr_got[wr_base + i]);
        check({tag, " wr_data"}, v, data[i]);
      end
    end
    if (do_stop) begin
      bus_stop();
      check({tag, " stop_pulses"}, stop_cnt - sp0, 1);
      check({tag, " busy_after_stop"}, busy_o, 0);
      check({tag, " match_after_stop"}, addr_match_o, 0);
    end
  endtask

  initial begin
    logic [7:0] q[$];
    logic b;
    logic ack;
    int st0;
    scl_m = 1'b1;
    sda_m = 1'b1;
    rst_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rst sda_o", sda_o, 1);
    check("rst scl_o", scl_o, 1);
    check("rst start_o", start_o, 0);
    check("rst stop_o", stop_o, 0);
    check("rst addr_match_o", addr_match_o, 0);
    check("rst op_o", op_o, 0);
    check("rst busy_o", busy_o, 0);
    check("rst wr_valid_o", wr_valid_o, 0);
    check("rst rd_req_o", rd_req_o, 0);
    check("rst wr_data_o", wr_data_o, 0);
    rst_i = 1'b1;
    repeat (5) @(negedge clk_i);

    // 32-byte write burst
    q.delete();
    for (int i = 0; i < 32; i++) q.push_back(8'(i));
    xfer(7'h22, 1'b0, q, 1, "wr32");
    check("wr32 wr_data_o_last", wr_data_o, 8'h1F);

    // 32-byte read burst, last byte NACKed
    q.delete();
    for (int i = 0; i < 32; i++) q.push_back(8'(100 + i));
    xfer(7'h22, 1'b1, q, 1, "rd32");

    // wrong device address
    q.delete();
    q.push_back(8'h55);
    xfer(7'h23, 1'b0, q, 1, "nack_addr");

    // alternating single-byte writes and reads
    for (int i = 0; i < 128; i++) begin
      q.delete();
      if (i % 2 == 0) begin
        q.push_back(8'(64 + i / 2));
        xfer(7'h22, 1'b0, q, 1, "alt_wr");
      end else begin
        q.push_back(8'(63 - (i - 1) / 2));
        xfer(7'h22, 1'b1, q, 1, "alt_rd");
      end
    end

    // write then repeated START into a read
    st0 = start_cnt;
    q.delete(); q.push_back(8'h11);
    xfer(7'h22, 1'b0, q, 0, "rs_wr");
    q.delete(); q.push_back(8'hB6);
    xfer(7'h22, 1'b1, q, 1, "rs_rd");
    check("rs start_pulses", start_cnt - st0, 2);

    // reset in the middle of a read byte
    rd_src.push_back(8'h00);
    bus_start();
    send_byte({7'h22, 1'b1}, ack);
    check("rstmid addr_ack", ack, 0);
    for (int i = 0; i < 3; i++) get_bit(b);
    wait_q();
    check("rstmid sda_driving", sda_o, 0);
    rst_i = 1'b0;
    #1;
    check("rstmid sda_o", sda_o, 1);
    check("rstmid busy_o", busy_o, 0);
    check("rstmid addr_match_o", addr_match_o, 0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    bus_stop();
    q.delete(); q.push_back(8'h5A); q.push_back(8'hC3);
    xfer(7'h22, 1'b0, q, 1, "rstmid_wr");

    // randomized transactions
    for (int k = 0; k < 12; k++) begin
      logic [6:0] a;
      logic rd;
      int n;
      rd = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 4);
      a = ($urandom_range(0, 4) == 0) ? (7'h22 ^ 7'($urandom_range(1, 127))) : 7'h22;
      q.delete();
      for (int j = 0; j < n; j++) q.push_back(8'($urandom));
      xfer(a, rd, q, 1, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_slave_if.md
Name: i2c_slave_if

Overview:
Synthesizable I2C slave responder. It is the device-side counterpart to the iicmb_m_wb I2C master controller. It oversamples SCL/SDA on the system clock, detects START/STOP, and matches a 7-bit device address. Received write bytes go to the user side; read bytes are requested from the user side and shifted onto SDA (open-drain). No clock stretching.

Parameters:
I2C_ADDR_WIDTH, 7, slave address width
I2C_DATA_WIDTH, 8, data byte width
I2C_DEVICE_ADDR, 7'h22, address this slave acknowledges

Ports:
clk_i  in  1  system clock; must be at least 8x SCL frequency
rst_i  in  1  asynchronous active-low reset
scl_i  in  1  I2C clock from bus
sda_i  in  1  I2C data from bus
scl_o  out  1  constant 1 (bus released; no stretching)
sda_o  out  1  open-drain data; 0 = pull low, 1 = release
start_o  out  1  one-cycle pulse on START or repeated START
stop_o  out  1  one-cycle pulse on STOP
addr_match_o  out  1  high from address ACK until STOP/START
op_o  out  1  R/W bit of current transfer; 0 = write, 1 = read
wr_valid_o  out  1  one-cycle pulse when a write byte is received
wr_data_o  out  I2C_DATA_WIDTH  last received write byte; held until next byte
rd_req_o  out  1  one-cycle pulse: next read byte needed
rd_data_i  in  I2C_DATA_WIDTH  read byte; sampled on SCL falling edge after rd_req_o
busy_o  out  1  high between START and STOP

Behaviour:
- Reset (rst_i=0, asynchronous):
  - State is IDLE.
  - sda_o=1, scl_o=1.
  - All pulses, addr_match_o, op_o and busy_o are 0.
  - wr_data_o=0.
  - Synchronizers reset to 1.
- Input sampling: scl_i/sda_i pass through 2-FF synchronizers, then a previous-value register for edge detection. All decisions use the synchronized values, so detection lags the pins by 2-3 clk_i cycles.
- START: sync SDA 1->0 while sync SCL=1.
  - Accepted in any state, including mid-byte (repeated START).
  - Goes to ADDR with bit counter 0 and releases sda_o.
  - Pulses start_o, sets busy_o, clears addr_match_o.
- STOP: sync SDA 0->1 while SCL=1.
  - Accepted in any state.
  - Goes to IDLE, releases sda_o, pulses stop_o, clears busy_o and addr_match_o.
- Bit sampling: SDA is sampled on the SCL rising edge, MSB first. sda_o changes only on the SCL falling edge, one cycle after detection.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits (7 address bits + R/W). After the 8th rising edge, compare the address with I2C_DEVICE_ADDR.
    - Match: latch op_o. On the next SCL falling edge drive sda_o=0 and enter ADDR_ACK.
    - Mismatch: go to IGNORE. sda_o stays 1, so the master sees a NACK.
  - ADDR_ACK: hold sda_o=0 through the 9th SCL high.
    - Set addr_match_o on entry.
    - If op_o=1, pulse rd_req_o at the 9th rising edge.
    - On the next falling edge: write goes to WR_BYTE with sda_o=1; read loads rd_data_i into the shift register, drives its MSB and goes to RD_BYTE.
  - WR_BYTE: shift 8 bits.
    - At the 8th rising edge: update wr_data_o and pulse wr_valid_o.
    - At the following falling edge: drive sda_o=0 and go to WR_ACK.
  - WR_ACK: at the next falling edge release sda_o and return to WR_BYTE. Every write byte is always ACKed.
  - RD_BYTE: on each falling edge present the next bit. After the 8th bit's falling edge, release sda_o and go to RD_ACK.
  - RD_ACK: sample the master ACK at the 9th rising edge.
    - 0 (ACK): pulse rd_req_o; at the falling edge reload from rd_data_i and go to RD_BYTE.
    - 1 (NACK): go to IGNORE.
  - IGNORE: sda_o=1; wait for STOP or START.
- rd_data_i must be valid within one SCL low phase after rd_req_o. No internal read buffer.
- A byte that is interrupted by START/STOP is discarded; no wr_valid_o is issued for it.
- Reset mid-transfer: state and outputs return to reset values immediately and sda_o is released. Bus activity is then ignored until the next START.

Test Plan:
- START, addr 0x44 (0x22 write), bytes 0x00..0x1F, STOP -> ACK on all 33 bytes; 32 wr_valid_o pulses with wr_data_o 0x00..0x1F in order; op_o=0; one start_o and one stop_o.
- START, addr 0x45, user supplies 100..131 on rd_req_o, master ACKs 31 bytes then NACKs the last -> bus bytes 0x64..0x83; 32 rd_req_o pulses; sda_o released after the NACK.
- Address 0x46 (device 0x23) write -> sda_o stays 1 at the 9th bit (NACK); no wr_valid_o; addr_match_o=0; stop_o still pulses.
- 128 alternating single-byte transfers: even iterations write 64+i/2; odd iterations read with value 63-(i-1)/2 and master NACK -> writes received 0x40..0x7F; reads return 0x3F..0x00.
- Write 0x11, then repeated START with a read (addr 0x45) -> start_o pulses twice; op_o changes 0->1; read byte driven correctly.
- Assert rst_i low in the middle of a read byte -> sda_o=1 immediately; busy_o=0; the next full write transaction is ACKed normally.
